// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, parity encodings and default oversampling shared by the UART Tx/Rx paths.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} rx_state_e;
  localparam logic [1:0] PAR_NONE0 = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_EVEN  = 2'b10;
  localparam logic [1:0] PAR_NONE3 = 2'b11;
  localparam int OVERSAMPLE_DEF = 16;
  function automatic logic parity_on(input logic [1:0] p);
    return (p == PAR_ODD) || (p == PAR_EVEN);
  endfunction
endpackage

// File: rtl/rx_sync.sv
// rx_sync: 2-flop synchronizer for the serial line, resetting to the idle (high) level.
module rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta_q, sync_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {sync_q, meta_q} <= 2'b11;
    else {sync_q, meta_q} <= {meta_q, d};
  assign q = sync_q;
endmodule

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: oversampling UART receiver; start detect, mid-bit LSB-first sampling, parity/stop checks.
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       Clock,
  input  logic       ResetN,
  input  logic       BaudTick,
  input  logic       RxIn,
  input  logic [1:0] ParityType,
  input  logic       StopBits,
  input  logic       DataLength,
  output logic [7:0] DataOut,
  output logic       DataValid,
  output logic       ParityError,
  output logic       StopError,
  output logic       Busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  rx_state_e state_q, state_d;
  logic [TW-1:0] tick_q, tick_d, tick_nx;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d, data_out_q, data_out_d;
  logic [1:0] par_cfg_q, par_cfg_d;
  logic stop2_q, stop2_d, len8_q, len8_d;
  logic par_err_q, par_err_d, stop_acc_q, stop_acc_d;
  logic data_valid_q, data_valid_d, parity_error_q, parity_error_d, stop_error_q, stop_error_d;
  logic rx, mid, full, last_data;

  rx_sync u_sync (.clk(Clock), .rst_n(ResetN), .d(RxIn), .q(rx));

  assign mid = tick_q == TW'(OVERSAMPLE / 2 - 1);
  assign full = tick_q == TW'(OVERSAMPLE - 1);
  assign tick_nx = full ? '0 : tick_q + 1'b1;
  assign last_data = bit_q == {2'b11, len8_q};

  always_comb begin
    state_d = state_q;
    tick_d = tick_q;
    bit_d = bit_q;
    shift_d = shift_q;
    par_cfg_d = par_cfg_q;
    stop2_d = stop2_q;
    len8_d = len8_q;
    par_err_d = par_err_q;
    stop_acc_d = stop_acc_q;
    data_out_d = data_out_q;
    data_valid_d = 1'b0;
    parity_error_d = parity_error_q;
    stop_error_d = stop_error_q;
    case (state_q)
      IDLE: if (!rx) begin
        state_d = START;
        tick_d = '0;
        bit_d = '0;
        shift_d = '0;
        par_err_d = 1'b0;
        stop_acc_d = 1'b0;
        par_cfg_d = ParityType;
        stop2_d = StopBits;
        len8_d = DataLength;
      end
      START: if (BaudTick) begin
        tick_d = mid ? '0 : tick_nx;
        state_d = !mid ? START : rx ? IDLE : DATA;
      end
      DATA: if (BaudTick) begin
        tick_d = tick_nx;
        if (full) begin
          shift_d = {rx, shift_q[7:1]};
          bit_d = last_data ? 3'd0 : bit_q + 3'd1;
          state_d = !last_data ? DATA : parity_on(par_cfg_q) ? PARITY : STOP;
        end
      end
      PARITY: if (BaudTick) begin
        tick_d = tick_nx;
        if (full) begin
          par_err_d = ^shift_q ^ rx ^ (par_cfg_q == PAR_ODD);
          state_d = STOP;
        end
      end
      STOP: if (BaudTick) begin
        tick_d = tick_nx;
        if (full) begin
          stop_acc_d = stop_acc_q | ~rx;
          bit_d = bit_q + 3'd1;
          // Outputs load on the last stop sample so DataValid is visible during DONE.
          if (bit_q[0] == stop2_q) begin
            state_d = DONE;
            data_valid_d = 1'b1;
            data_out_d = len8_q ? shift_q : {1'b0, shift_q[7:1]};
            parity_error_d = par_err_q;
            stop_error_d = stop_acc_q | ~rx;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN)
    if (!ResetN) begin
      state_q <= IDLE;
      tick_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      par_cfg_q <= PAR_NONE0;
      stop2_q <= 1'b0;
      len8_q <= 1'b0;
      par_err_q <= 1'b0;
      stop_acc_q <= 1'b0;
      data_out_q <= '0;
      data_valid_q <= 1'b0;
      parity_error_q <= 1'b0;
      stop_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q <= tick_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      par_cfg_q <= par_cfg_d;
      stop2_q <= stop2_d;
      len8_q <= len8_d;
      par_err_q <= par_err_d;
      stop_acc_q <= stop_acc_d;
      data_out_q <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_error_q <= parity_error_d;
      stop_error_q <= stop_error_d;
    end

  assign DataOut = data_out_q;
  assign DataValid = data_valid_q;
  assign ParityError = parity_error_q;
  assign StopError = stop_error_q;
  assign Busy = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer: directed frames with hand-computed results for the UART receive deframer.
module tb_uart_rx_deframer;
  localparam int OS = 16;
  localparam int BIT_CLKS = 2 * OS;
  logic Clock = 0, ResetN = 0, BaudTick = 0, RxIn = 1, StopBits = 0, DataLength = 1;
  logic [1:0] ParityType = 2'b00;
  logic [7:0] DataOut;
  logic DataValid, ParityError, StopError, Busy;
  int errors = 0, checks = 0, cyc = 0, dv_hi = 0, dv_rise = 0, dv_cyc = 0, start_cyc = 0;
  int hi0 = 0, rise0 = 0;
  logic dv_prev = 0;

  uart_rx_deframer #(.OVERSAMPLE(OS)) dut (
    .Clock(Clock), .ResetN(ResetN), .BaudTick(BaudTick), .RxIn(RxIn),
    .ParityType(ParityType), .StopBits(StopBits), .DataLength(DataLength),
    .DataOut(DataOut), .DataValid(DataValid), .ParityError(ParityError),
    .StopError(StopError), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  initial forever begin
    @(negedge Clock);
    BaudTick = ~BaudTick;
  end

  initial forever begin
    @(negedge Clock);
    cyc++;
    if (DataValid) begin
      dv_hi++;
      if (!dv_prev) begin
        dv_rise++;
        dv_cyc = cyc;
      end
    end
    dv_prev = DataValid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    RxIn = b;
    repeat (BIT_CLKS) @(negedge Clock);
  endtask

  task automatic snap();
    hi0 = dv_hi;
    rise0 = dv_rise;
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input int pbit,
                            input logic s1, input logic s2, input int nstop);
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(d[i]);
    if (pbit >= 0) send_bit(pbit[0]);
    send_bit(s1);
    if (nstop == 2) send_bit(s2);
    send_bit(1'b1);
  endtask

  initial begin
    repeat (4) @(negedge Clock);
    chk("rst_dataout", DataOut, 0);
    chk("rst_valid", DataValid, 0);
    chk("rst_perr", ParityError, 0);
    chk("rst_serr", StopError, 0);
    chk("rst_busy", Busy, 0);
    ResetN = 1;
    repeat (4) @(negedge Clock);

    ParityType = 2'b00; StopBits = 0; DataLength = 1;
    snap();
    send_frame(8'hA5, 8, -1, 1'b1, 1'b1, 1);
    chk("8n1_data", DataOut, 8'hA5);
    chk("8n1_perr", ParityError, 0);
    chk("8n1_serr", StopError, 0);
    chk("8n1_busy", Busy, 0);
    chk("8n1_pulses", dv_rise - rise0, 1);
    chk("8n1_width", dv_hi - hi0, 1);
    chk("8n1_latency_ok", (dv_cyc - start_cyc >= 300) && (dv_cyc - start_cyc <= 312), 1);

    ParityType = 2'b10; StopBits = 1; DataLength = 0;
    snap();
    send_frame(8'h55, 7, 0, 1'b1, 1'b1, 2);
    chk("7e2_data", DataOut, 8'h55);
    chk("7e2_perr", ParityError, 0);
    chk("7e2_serr", StopError, 0);
    chk("7e2_pulses", dv_rise - rise0, 1);
    send_frame(8'h55, 7, 1, 1'b1, 1'b1, 2);
    chk("7e2_bad_perr", ParityError, 1);
    chk("7e2_bad_data", DataOut, 8'h55);

    ParityType = 2'b01; StopBits = 0; DataLength = 1;
    send_frame(8'h3C, 8, 0, 1'b1, 1'b1, 1);
    chk("8o1_bad_perr", ParityError, 1);
    chk("8o1_bad_data", DataOut, 8'h3C);
    send_frame(8'h3C, 8, 1, 1'b1, 1'b1, 1);
    chk("8o1_good_perr", ParityError, 0);
    chk("8o1_good_data", DataOut, 8'h3C);

    ParityType = 2'b00; StopBits = 1; DataLength = 1;
    snap();
    send_frame(8'hFF, 8, -1, 1'b1, 1'b0, 2);
    chk("8n2_serr", StopError, 1);
    chk("8n2_data", DataOut, 8'hFF);
    chk("8n2_perr", ParityError, 0);
    chk("8n2_pulses", dv_rise - rise0, 1);
    chk("8n2_busy", Busy, 0);

    StopBits = 0;
    snap();
    RxIn = 0;
    repeat (OS / 4 * 2) @(negedge Clock);
    RxIn = 1;
    repeat (BIT_CLKS) @(negedge Clock);
    chk("glitch_pulses", dv_rise - rise0, 0);
    chk("glitch_data", DataOut, 8'hFF);
    chk("glitch_serr", StopError, 1);
    chk("glitch_busy", Busy, 0);
    send_frame(8'h12, 8, -1, 1'b1, 1'b1, 1);
    chk("after_glitch_data", DataOut, 8'h12);
    chk("after_glitch_serr", StopError, 0);

    snap();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    chk("midframe_busy", Busy, 1);
    ResetN = 0;
    #1;
    chk("abort_data", DataOut, 0);
    chk("abort_valid", DataValid, 0);
    chk("abort_perr", ParityError, 0);
    chk("abort_serr", StopError, 0);
    chk("abort_busy", Busy, 0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    ResetN = 1;
    send_bit(1'b1);
    chk("abort_pulses", dv_rise - rise0, 0);
    snap();
    send_frame(8'h7E, 8, -1, 1'b1, 1'b1, 1);
    chk("after_abort_data", DataOut, 8'h7E);
    chk("after_abort_perr", ParityError, 0);
    chk("after_abort_serr", StopError, 0);
    chk("after_abort_pulses", dv_rise - rise0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_deframer.md
# uart_rx_deframer

Receive-side counterpart of the UART transmit frame path. The block oversamples the serial line, detects a start bit and samples data LSB-first at mid-bit. It then checks the optional parity bit and one or two stop bits, and presents a parallel byte with a one-cycle valid strobe and error flags. It sits between the Rx baud-tick generator and the Rx host/FIFO, and uses the same configuration encodings as the transmit side.

## Interface
- OVERSAMPLE, 16, BaudTick pulses per bit period; even, ≥4.
- Clock  in  1  system clock; all logic on rising edge.
- ResetN  in  1  asynchronous, active-low reset.
- BaudTick  in  1  one-Clock enable pulse at OVERSAMPLE× baud rate.
- RxIn  in  1  serial line; idle high; asynchronous to Clock.
- ParityType  in  2  00/11 = no parity, 01 = odd, 10 = even.
- StopBits  in  1  0 = one stop bit, 1 = two stop bits.
- DataLength  in  1  0 = 7 data bits, 1 = 8 data bits.
- DataOut  out  8  received data; bit 7 forced to 0 in 7-bit mode.
- DataValid  out  1  one-Clock pulse when a frame completes.
- ParityError  out  1  parity mismatch on the last completed frame.
- StopError  out  1  low stop bit (framing error) on the last completed frame.
- Busy  out  1  high from start detect until return to IDLE.

## Operation
- RxIn passes through a 2-flop synchronizer; all decisions use the synchronized value.
- ParityType, StopBits and DataLength are latched at start detect. Changes mid-frame are ignored.
- Tick counter: counts BaudTick from 0 to OVERSAMPLE-1 and advances only on BaudTick.
- States: IDLE, START, DATA, PARITY, STOP, DONE.
- IDLE: synchronized RxIn low → START, clear tick counter, Busy=1.
- START: at tick OVERSAMPLE/2-1 (mid start bit):
  - if the line is low → DATA, reset tick counter;
  - if the line is high → IDLE (glitch rejected, no outputs change).
- DATA: sample at every OVERSAMPLE-th tick and shift right into the data register (LSB first).
  - After 7 or 8 samples (latched DataLength): parity enabled → PARITY, else → STOP.
- PARITY: sample one bit. Error when the parity check fails:
  - odd: XOR of data bits and parity bit ≠ 1;
  - even: XOR of data bits and parity bit ≠ 0.
- STOP: sample 1 or 2 stop bits. Any sampled 0 sets StopError for this frame. Sampling does not stop early.
- DONE: lasts one Clock.
  - Loads DataOut, ParityError and StopError together and pulses DataValid.
  - → IDLE, Busy=0.
- With no parity, ParityError is loaded 0.
- Frames with a StopError are still delivered; the host decides what to do with them.
- Outputs hold their values until the next DONE.

## Timing
- Reset values: DataOut=0, DataValid=0, ParityError=0, StopError=0, Busy=0, state IDLE, counters 0.
- ResetN asserted mid-frame aborts the frame immediately. No DataValid is produced and outputs return to reset values.
- Synchronizer latency: 2 Clocks from an RxIn edge to its use.
- DataValid rises exactly 1 Clock after the BaudTick on which the last stop bit is sampled. It is high for exactly 1 Clock.
- Back-to-back frames: the block reaches IDLE at mid last-stop-bit, so the next start edge up to half a bit later is detected. No frame is lost at 0% baud error.
- BaudTick held low freezes the FSM in its current state. Only IDLE start detection runs on every Clock.
- A start edge arriving in the same Clock as DONE is seen in IDLE on the next Clock. It is not lost, because the line stays low.

## Structure
- Shared package uart_pkg holds:
  - the state enum (IDLE..DONE);
  - parity encodings PAR_NONE0=00, PAR_ODD=01, PAR_EVEN=10, PAR_NONE3=11;
  - the default OVERSAMPLE constant.
- The transmit side uses the same parity encodings.
- One sub-module: rx_sync, a 2-flop synchronizer with reset-to-1 (idle) output.
- The FSM, tick/bit counters and shift register stay in uart_rx_deframer.

## Test plan
- 8N1, send 0xA5 → DataOut=0xA5; one DataValid pulse ≈ 9.5 bit times after the start edge; ParityError=0, StopError=0; Busy low afterwards.
- 7E2, send 0x55 with parity 0 and two stop bits → DataOut=0x55, no errors. Repeat with 0x55 and parity 1 → ParityError=1, DataOut=0x55.
- 8O1, send 0x3C with parity bit 0 (should be 1) → ParityError=1. Next frame 0x3C with parity 1 → ParityError clears to 0.
- 8N2, send 0xFF with the second stop bit driven low → StopError=1, DataOut=0xFF, DataValid pulses.
- Glitch: RxIn low for OVERSAMPLE/4 ticks, then high → returns to IDLE, no DataValid, outputs unchanged. Then a valid 0x12 frame is received correctly.
- Reset mid-frame: assert ResetN low during DATA of a 0x81 frame → all outputs 0 immediately, no DataValid. After release, the next frame 0x7E is received correctly.
